multicycle_data_memory: RTL and testbench
=========================================

MULTICYCLE_DATA_MEMORY -- requirements
Module: multicycle_data_memory

Interface
REQ-001 SHALL have parameter MEM_DEPTH, 16384, number of 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter LATENCY, 4, cycles from request acceptance to completion; at least 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port addr  input  32  byte address of the access.
REQ-006 SHALL have port din  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 SHALL have port mem_read  input  1  load request.
REQ-008 SHALL have port mem_write  input  1  store request.
REQ-009 SHALL have port funct3  input  3  access size: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-010 SHALL have port dout  output  32  load result, sign- or zero-extended per funct3.
REQ-011 SHALL have port is_ready  output  1  block idle and able to accept a request.
REQ-012 SHALL have port is_output_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port misaligned  output  1  completed access was misaligned (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; is_ready high only in IDLE.
REQ-015 SHALL accept a request on a rising edge in IDLE with mem_read or mem_write high, capturing addr, din, funct3 and the request type, and enter BUSY with the counter cleared.
REQ-016 SHALL ignore all request inputs in BUSY and DONE; captured values alone determine the access.
REQ-017 SHALL stay in BUSY until LATENCY edges after acceptance, then perform the access on that edge and enter DONE.
REQ-018 SHALL hold is_output_valid high for exactly the one DONE cycle, then return to IDLE on the next edge.
REQ-019 SHALL accept back-to-back requests; the minimum request-to-request spacing is LATENCY+2 edges.
REQ-020 SHALL treat mem_read and mem_write both high as a write only.
REQ-021 SHALL form word index from addr[log2(MEM_DEPTH)+1:2]; higher address bits are ignored (wrap-around).
REQ-022 SHALL be little-endian: byte lane addr[1:0], half lane addr[1]; a store modifies only the addressed lanes.
REQ-023 SHALL register dout on read completion; dout holds its value at all other times, including write completions.
REQ-024 SHALL treat funct3 values 011, 110 and 111 as word accesses.

Reset
REQ-025 SHALL, while reset is low, force state IDLE, counter 0, dout 0, is_output_valid 0 and misaligned 0, independent of clk.
REQ-026 SHALL zero every memory word while reset is low.
REQ-027 SHALL abort an in-flight access when reset is asserted in BUSY; no memory write occurs and no completion pulse is produced.
REQ-028 SHALL assert is_ready from the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL, with DMEM_MISALIGN_TRAP_EN defined, flag a half access with addr[0]=1 or a word access with addr[1:0]!=0 as misaligned; on completion it suppresses any write, sets dout to 0 for a load, and asserts misaligned together with is_output_valid.
REQ-030 SHALL, without DMEM_MISALIGN_TRAP_EN, hold misaligned at 0; the access is performed with the low address bits cleared to the access's natural alignment.

Verification
REQ-031 SHALL cover this scenario: LATENCY=4, write 0xDEADBEEF to addr 0x10 with funct3=010, then read word 0x10 -> is_output_valid exactly 4 edges after each acceptance, and dout=0xDEADBEEF.
REQ-032 SHALL cover this scenario: byte store din=0x000000AA to addr 0x11, then read word 0x10 -> 0xDEADAAEF; lb at 0x11 -> 0xFFFFFFAA; lbu at 0x11 -> 0x000000AA.
REQ-033 SHALL cover this scenario: reset pulsed low 2 cycles after accepting a write of 0x12345678 to addr 0x20 -> no completion pulse, then read 0x20 -> 0x00000000.
REQ-034 SHALL cover this scenario: MEM_DEPTH=16, write 0x5 to addr 0x40, then read addr 0x00 -> 0x00000005 (wrap-around).
REQ-035 SHALL cover this scenario: with DMEM_MISALIGN_TRAP_EN defined, a word write to addr 0x22 -> misaligned=1 with the completion pulse and memory unchanged; without the macro, the same write lands at 0x20.
REQ-036 SHALL cover this scenario: mem_read=mem_write=1 with addr=0x30, din=0x7 and dout previously 0x99 -> word 0x30 becomes 0x7 and dout stays 0x99.

Source files
------------

// File: rtl/multicycle_data_memory.sv
// multicycle_data_memory: byte-addressable data memory with a fixed
// multi-cycle access latency and a one-cycle completion pulse.
// A request is captured in IDLE, waits LATENCY edges in BUSY, performs the
// access on the last BUSY edge and signals completion during DONE.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to flag and suppress
// misaligned half/word accesses instead of silently aligning them.
module multicycle_data_memory #(
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic [31:0] dout,
  output logic        is_ready,
  output logic        is_output_valid,
  output logic        misaligned
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic [AW+1:0]   addr_q_r;
  logic [31:0]     din_q_r;
  logic [2:0]      funct3_q_r;
  logic            write_q_r;
  logic [31:0]     mem_r [MEM_DEPTH];

  logic            is_byte_s;
  logic            is_half_s;
  logic            zero_ext_s;
  logic            trap_s;
  logic [AW+1:0]   eff_addr_s;
  logic [AW-1:0]   word_idx_s;
  logic [1:0]      lane_s;
  logic [31:0]     old_word_s;
  logic [31:0]     store_word_s;
  logic [31:0]     load_word_s;
  logic            finish_s;
  logic            do_write_s;

  // Address bits above the memory span are deliberately ignored (wrap-around).
  generate
    if (AW + 2 < 32) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^addr[31:AW+2];
    end
  endgenerate

  // Merge right-aligned store data into the addressed lanes of a word.
  function automatic logic [31:0] merge_store(
    input logic [31:0] old_word,
    input logic [31:0] data,
    input logic [1:0]  lane,
    input logic        is_byte,
    input logic        is_half
  );
    logic [31:0] r;
    r = old_word;
    if (is_byte) begin
      case (lane)
        2'b00:   r[7:0]   = data[7:0];
        2'b01:   r[15:8]  = data[7:0];
        2'b10:   r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else if (is_half) begin
      if (lane[1]) begin
        r[31:16] = data[15:0];
      end else begin
        r[15:0] = data[15:0];
      end
    end else begin
      r = data;
    end
    return r;
  endfunction

  // Pull the addressed lane out of a word and sign- or zero-extend it.
  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic        is_byte,
    input logic        is_half,
    input logic        zero_ext
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    if (is_byte) begin
      r = zero_ext ? {24'h000000, b} : {{24{b[7]}}, b};
    end else if (is_half) begin
      r = zero_ext ? {16'h0000, h} : {{16{h[15]}}, h};
    end else begin
      r = word;
    end
    return r;
  endfunction

  // Decode the captured request: size, alignment, word index and data paths.
  always_comb begin
    is_byte_s  = (funct3_q_r[1:0] == 2'b00);
    is_half_s  = (funct3_q_r[1:0] == 2'b01);
    zero_ext_s = funct3_q_r[2] && (is_byte_s || is_half_s);
`ifdef DMEM_MISALIGN_TRAP_EN
    trap_s = (is_half_s && addr_q_r[0]) ||
             (!is_byte_s && !is_half_s && (addr_q_r[1:0] != 2'b00));
`else
    trap_s = 1'b0;
`endif
    if (is_byte_s) begin
      eff_addr_s = addr_q_r;
    end else if (is_half_s) begin
      eff_addr_s = {addr_q_r[AW+1:1], 1'b0};
    end else begin
      eff_addr_s = {addr_q_r[AW+1:2], 2'b00};
    end
    word_idx_s   = eff_addr_s[AW+1:2];
    lane_s       = eff_addr_s[1:0];
    old_word_s   = mem_r[word_idx_s];
    store_word_s = merge_store(old_word_s, din_q_r, lane_s, is_byte_s, is_half_s);
    load_word_s  = load_extract(old_word_s, lane_s, is_byte_s, is_half_s, zero_ext_s);
    finish_s     = (state_r == BUSY) && (count_r == LAST_COUNT);
    do_write_s   = finish_s && write_q_r && !trap_s;
  end

  // Storage array: cleared while reset is held, updated on a completing store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= 32'h00000000;
      end
    end else if (do_write_s) begin
      mem_r[word_idx_s] <= store_word_s;
    end
  end

  // Request FSM: capture, latency count, completion pulse and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      count_r         <= '0;
      addr_q_r        <= '0;
      din_q_r         <= 32'h00000000;
      funct3_q_r      <= 3'b000;
      write_q_r       <= 1'b0;
      dout            <= 32'h00000000;
      is_ready        <= 1'b0;
      is_output_valid <= 1'b0;
      misaligned      <= 1'b0;
    end else begin
      is_output_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr_q_r   <= addr[AW+1:0];
            din_q_r    <= din;
            funct3_q_r <= funct3;
            write_q_r  <= mem_write;
            count_r    <= '0;
            state_r    <= BUSY;
            is_ready   <= 1'b0;
          end else begin
            is_ready   <= 1'b1;
          end
        end
        BUSY: begin
          if (finish_s) begin
            state_r         <= DONE;
            is_output_valid <= 1'b1;
            misaligned      <= trap_s;
            if (!write_q_r) begin
              dout <= trap_s ? 32'h00000000 : load_word_s;
            end else begin
              dout <= dout;
            end
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        DONE: begin
          state_r  <= IDLE;
          is_ready <= 1'b1;
        end
        default: begin
          state_r  <= IDLE;
          is_ready <= 1'b0;
          count_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_data_memory.sv
// Self-checking bench for multicycle_data_memory (MEM_DEPTH=16, LATENCY=4).
// A byte-array reference model produces expected results that are queued at
// request acceptance and compared when the completion pulse appears.
module tb_multicycle_data_memory;

  localparam int DEPTH = 16;
  localparam int LAT   = 4;
  localparam int NBYTE = DEPTH * 4;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] din;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] dout;
  logic        is_ready;
  logic        is_output_valid;
  logic        misaligned;

  typedef struct packed {
    logic [31:0] dout;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mb [NBYTE];
  logic [31:0] model_dout;
  int          n_checks;
  int          n_errors;

  multicycle_data_memory #(.MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .addr            (addr),
    .din             (din),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .funct3          (funct3),
    .dout            (dout),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .misaligned      (misaligned)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
    model_dout = 32'h00000000;
  endtask

  // Reference behaviour of one access on a little-endian byte array.
  task automatic model_step(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] ed, output logic em);
    int nb;
    int base;
    logic sgn;
    logic mis;
    logic trap;
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: nb = 1;
      3'b001, 3'b101: nb = 2;
      default:        nb = 4;
    endcase
    sgn  = (f3 == 3'b000) || (f3 == 3'b001);
    mis  = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    base = (int'(a) % NBYTE) & ~(nb - 1);
    if (trap) begin
      if (!wr && rd) model_dout = 32'h00000000;
    end else if (wr) begin
      for (int k = 0; k < nb; k++) mb[base + k] = d[8*k +: 8];
    end else begin
      v = 32'h00000000;
      for (int k = 0; k < nb; k++) v[8*k +: 8] = mb[base + k];
      if (sgn && nb == 1) v = {{24{v[7]}}, v[7:0]};
      if (sgn && nb == 2) v = {{16{v[15]}}, v[15:0]};
      model_dout = v;
    end
    ed = model_dout;
    em = trap;
  endtask

  // Issue one request, scoreboard it and check latency, result and pulse width.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int waited;
    int cycles;
    exp_t e;
    logic [31:0] ed;
    logic em;
    waited = 0;
    while (!is_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_ready"}, {31'd0, is_ready}, 32'd1);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; din = d;
    @(posedge clk);
    model_step(rd, wr, f3, a, d, ed, em);
    e.dout = ed;
    e.mis  = em;
    sb_q.push_back(e);
    #1;
    // Garbage request while busy must be ignored.
    mem_read = 1'b1; mem_write = 1'b1;
    addr = $urandom; din = $urandom; funct3 = 3'($urandom_range(0, 7));
    check({tag, "_busy"}, {31'd0, is_ready}, 32'd0);
    cycles = 0;
    while (!is_output_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    if (is_output_valid) begin
      check({tag, "_latency"}, cycles, LAT);
      e = sb_q.pop_front();
      check({tag, "_dout"}, dout, e.dout);
      check({tag, "_mis"}, {31'd0, misaligned}, {31'd0, e.mis});
    end else begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, is_output_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, is_ready}, 32'd1);
    @(negedge clk);
  endtask

  // Stimulus sequence.
  initial begin
    int seen;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'h0; din = 32'h0; funct3 = 3'b000;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 32'h0);
    check("rst_valid", {31'd0, is_output_valid}, 32'd0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", {31'd0, is_ready}, 32'd1);
    @(negedge clk);

    do_req("sw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req("lw10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    do_req("sb11", 1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AA);
    do_req("lw10b", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    do_req("lb11", 1'b1, 1'b0, 3'b000, 32'h11, 32'h0);
    do_req("lbu11", 1'b1, 1'b0, 3'b100, 32'h11, 32'h0);
    do_req("sh12", 1'b0, 1'b1, 3'b001, 32'h12, 32'hFFFF8001);
    do_req("lh12", 1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
    do_req("lhu12", 1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
    do_req("lw011", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    do_req("sw40", 1'b0, 1'b1, 3'b010, 32'h40, 32'h00000005);
    do_req("lw00", 1'b1, 1'b0, 3'b010, 32'h00, 32'h0);
    do_req("sw34", 1'b0, 1'b1, 3'b010, 32'h34, 32'h00000099);
    do_req("lw34", 1'b1, 1'b0, 3'b010, 32'h34, 32'h0);
    do_req("rw30", 1'b1, 1'b1, 3'b010, 32'h30, 32'h00000007);
    do_req("lw30", 1'b1, 1'b0, 3'b110, 32'h30, 32'h0);
    do_req("sw22", 1'b0, 1'b1, 3'b010, 32'h22, 32'hCAFEF00D);
    do_req("lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    do_req("lh13", 1'b1, 1'b0, 3'b001, 32'h13, 32'h0);

    // Reset during BUSY aborts the in-flight write.
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h20; din = 32'h12345678;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_dout", dout, 32'h0);
    check("abort_valid", {31'd0, is_output_valid}, 32'd0);
    model_clear();
    sb_q.delete();
    seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (is_output_valid) seen = 1;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", {31'd0, is_ready}, 32'd1);
    repeat (LAT + 2) begin
      if (is_output_valid) seen = 1;
      @(posedge clk);
      #1;
    end
    check("abort_no_pulse", seen, 32'd0);
    @(negedge clk);
    do_req("lw20r", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
